// File: rtl/blink_pkg.sv
// Shared definitions for the blink pattern monitor: widths, FSM state encoding,
// error codes and the rotate helper used to predict the next pattern value.
package blink_pkg;

    // Width of the observed blinker pattern
    localparam int PAT_W = 4;

    // Width of the dwell counter (and of last_dwell)
    localparam int CNT_W = 19;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    // err_code values
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_SEQ    = 2'd1;
    localparam logic [1:0] ERR_TIMING = 2'd2;
    localparam logic [1:0] ERR_STALL  = 2'd3;

    // Rotate a pattern left by one position (MSB wraps into LSB)
    function automatic logic [PAT_W-1:0] rotl1(input logic [PAT_W-1:0] v);
        return {v[PAT_W-2:0], v[PAT_W-1]};
    endfunction

endpackage

// File: rtl/blink_dwell_counter.sv
// Dwell counter for the blink monitor. Restarts at 1 on a pattern change,
// otherwise counts up and sticks at full scale. thresh_hit flags the cycle in
// which the count equals THRESH, so a long dwell is reported exactly once.
module blink_dwell_counter
    import blink_pkg::*;
#(
    parameter int unsigned THRESH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    output logic [CNT_W-1:0] count,
    output logic             thresh_hit
);

    localparam int unsigned      CNT_MAX_I = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_MAX_I);
    // A threshold beyond full scale is clamped so the compare stays meaningful
    localparam logic [CNT_W-1:0] THRESH_C  = (THRESH > CNT_MAX_I) ? CNT_MAX : CNT_W'(THRESH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a change restarts the dwell at 1 and wins over saturation
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign thresh_hit = (count_q == THRESH_C);

endmodule

// File: rtl/blink_monitor.sv
// Blink pattern monitor. Watches a 4-bit one-hot rotating blinker, checks that
// each step is the expected rotate-left and that each value is held for
// DWELL_CYCLES +/- DWELL_TOL clocks, and asserts locked after LOCK_N good steps.
// Optional stall detection is enabled by defining BLINK_MONITOR_STALL_EN.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned DWELL_TOL    = 16,
    parameter int unsigned LOCK_N       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PAT_W-1:0] pattern,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] last_dwell,
    output logic [15:0]      change_cnt
);

    // Accepted dwell window
    localparam int unsigned      DWELL_MAX_I = DWELL_CYCLES + DWELL_TOL;
    localparam int unsigned      DWELL_MIN_I = (DWELL_TOL > DWELL_CYCLES) ? 32'd0
                                                                          : DWELL_CYCLES - DWELL_TOL;
    localparam logic [CNT_W-1:0] DWELL_MIN_C = CNT_W'(DWELL_MIN_I);
    localparam logic [CNT_W-1:0] DWELL_MAX_C = CNT_W'(DWELL_MAX_I);

    // Good-change counter must be able to hold LOCK_N itself
    localparam int unsigned       GOOD_W   = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] LOCK_N_C = GOOD_W'(LOCK_N);

    // Registered state
    logic [PAT_W-1:0]  pattern_q;
    state_e            state_q,      state_d;
    logic [GOOD_W-1:0] good_q,       good_d;
    logic              locked_q,     locked_d;
    logic              err_q,        err_d;
    logic [1:0]        err_code_q,   err_code_d;
    logic [CNT_W-1:0]  last_dwell_q, last_dwell_d;
    logic [15:0]       change_cnt_q, change_cnt_d;

    // Change classification
    logic              change;
    logic              seq_good;
    logic              tim_good;
    logic              chk_fail;
    logic [1:0]        fail_code;
    logic [GOOD_W-1:0] good_inc;

    // Dwell counter interface
    logic [CNT_W-1:0]  dwell_count;
    logic              stall_hit;

    assign change = (pattern != pattern_q);

    blink_dwell_counter #(
        .THRESH (DWELL_MAX_I + 32'd1)
    ) u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (change),
        .count      (dwell_count),
        .thresh_hit (stall_hit)
    );

`ifndef BLINK_MONITOR_STALL_EN
    // Threshold output has no consumer when stall detection is compiled out
    logic unused_stall_hit;
    assign unused_stall_hit = stall_hit;
`endif

    // Judge the step being taken this cycle; sequence failures outrank timing
    always_comb begin
        seq_good  = (pattern == rotl1(pattern_q)) && $onehot(pattern);
        tim_good  = (dwell_count >= DWELL_MIN_C) && (dwell_count <= DWELL_MAX_C);
        chk_fail  = !(seq_good && tim_good);
        fail_code = seq_good ? ERR_TIMING : ERR_SEQ;
        good_inc  = good_q + 1'b1;
    end

    // Lock FSM plus error reporting; err is registered so it trails the change by one cycle
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (change) begin
            case (state_q)
                ST_SEARCH: begin
                    // First dwell is partial: nothing to judge yet
                    state_d = ST_ALIGN;
                    good_d  = '0;
                end
                ST_ALIGN: begin
                    if (chk_fail) begin
                        err_d      = 1'b1;
                        err_code_d = fail_code;
                        state_d    = ST_SEARCH;
                    end else if (LOCK_N <= 1) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_TRACK;
                        good_d  = {{(GOOD_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_TRACK: begin
                    if (chk_fail) begin
                        err_d      = 1'b1;
                        err_code_d = fail_code;
                        state_d    = ST_SEARCH;
                    end else if (good_inc == LOCK_N_C) begin
                        state_d = ST_LOCKED;
                    end else begin
                        good_d = good_inc;
                    end
                end
                ST_LOCKED: begin
                    if (chk_fail) begin
                        err_d      = 1'b1;
                        err_code_d = fail_code;
                        state_d    = ST_SEARCH;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
`ifdef BLINK_MONITOR_STALL_EN
        // A change in the same cycle takes precedence, hence the else
        else if (stall_hit && (state_q != ST_SEARCH)) begin
            err_d      = 1'b1;
            err_code_d = ERR_STALL;
            state_d    = ST_SEARCH;
        end
`endif
        locked_d = (state_d == ST_LOCKED);
    end

    // Dwell capture and change counting (change_cnt wraps naturally)
    always_comb begin
        last_dwell_d = last_dwell_q;
        change_cnt_d = change_cnt_q;
        if (change) begin
            last_dwell_d = dwell_count;
            change_cnt_d = change_cnt_q + 1'b1;
        end
    end

    // State registers; reset discards all tracking progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q    <= '0;
            state_q      <= ST_SEARCH;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            last_dwell_q <= '0;
            change_cnt_q <= '0;
        end else begin
            pattern_q    <= pattern;
            state_q      <= state_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            last_dwell_q <= last_dwell_d;
            change_cnt_q <= change_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign last_dwell = last_dwell_q;
    assign change_cnt = change_cnt_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed testbench for blink_monitor with DWELL_CYCLES=10, DWELL_TOL=1, LOCK_N=4.
// Inputs change just after the falling edge; outputs are sampled at falling edges.
module tb_blink_monitor;

`ifdef BLINK_MONITOR_STALL_EN
    localparam bit STALL       = 1'b1;
    localparam int FAULT_DWELL = 8;
`else
    localparam bit STALL       = 1'b0;
    localparam int FAULT_DWELL = 13;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pattern = 4'b0000;
    logic        locked;
    logic        err;
    logic [1:0]  err_code;
    logic [18:0] last_dwell;
    logic [15:0] change_cnt;

    int checks = 0;
    int fails = 0;
    int err_pulses = 0;

    blink_monitor #(
        .DWELL_CYCLES (10),
        .DWELL_TOL    (1),
        .LOCK_N       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pattern    (pattern),
        .locked     (locked),
        .err        (err),
        .err_code   (err_code),
        .last_dwell (last_dwell),
        .change_cnt (change_cnt)
    );

    always #5 clk = ~clk;

    // Count err-high cycles (value before each rising edge)
    always @(posedge clk) begin
        if (err === 1'b1) err_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic apply(input logic [3:0] p, input int n);
        pattern = p;
        repeat (n) @(negedge clk);
    endtask

    // From SEARCH: one unchecked change then four good rotates -> locked
    task automatic lock_up(input logic [3:0] start);
        logic [3:0] v;
        v = start;
        apply(v, 10);
        for (int k = 0; k < 4; k++) begin
            v = {v[2:0], v[3]};
            apply(v, 10);
        end
        checks++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_up_locked: got %0b expected 1", locked);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        checks++; if (last_dwell !== 19'd0) begin fails++; $display("FAIL reset_last_dwell: got %0d expected 0", last_dwell); end
        checks++; if (change_cnt !== 16'd0) begin fails++; $display("FAIL reset_change_cnt: got %0d expected 0", change_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_clean_lock();
        logic [3:0] seq_v [6];
        logic       exp_l [6];
        int base;
        seq_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        base = err_pulses;
        for (int i = 0; i < 6; i++) begin
            apply(seq_v[i], 10);
            checks++;
            if (locked !== exp_l[i]) begin
                fails++;
                $display("FAIL clean_locked[%0d]: got %0b expected %0b", i, locked, exp_l[i]);
            end
        end
        checks++; if (last_dwell !== 19'd10) begin fails++; $display("FAIL clean_last_dwell: got %0d expected 10", last_dwell); end
        checks++; if (change_cnt !== 16'd6) begin fails++; $display("FAIL clean_change_cnt: got %0d expected 6", change_cnt); end
        checks++; if (err_pulses !== base) begin fails++; $display("FAIL clean_no_err: got %0d pulses expected %0d", err_pulses, base); end
        $display("test_clean_lock done");
    endtask

    task automatic test_sequence_fault();
        int base;
        base = err_pulses;
        apply(4'b1000, 1);  // 0010 -> 1000 skips a step
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL seq_err: got %0b expected 1", err); end
        checks++; if (err_code !== 2'd1) begin fails++; $display("FAIL seq_err_code: got %0d expected 1", err_code); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL seq_locked: got %0b expected 0", locked); end
        apply(4'b1000, 1);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL seq_err_one_cycle: got %0b expected 0", err); end
        apply(4'b1000, 8);
        apply(4'b0100, 10); // wrong step but unchecked because state is SEARCH
        apply(4'b1000, 10);
        apply(4'b0001, 10);
        apply(4'b0010, 10);
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL seq_relock_early: got %0b expected 0", locked); end
        apply(4'b0100, 10);
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL seq_relock: got %0b expected 1", locked); end
        checks++; if (err_pulses !== base + 1) begin fails++; $display("FAIL seq_pulse_count: got %0d expected %0d", err_pulses, base + 1); end
        $display("test_sequence_fault done");
    endtask

    task automatic test_timing_fault();
        apply(4'b1000, FAULT_DWELL);
        apply(4'b0001, 1);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL timing_err: got %0b expected 1", err); end
        checks++; if (err_code !== 2'd2) begin fails++; $display("FAIL timing_err_code: got %0d expected 2", err_code); end
        checks++; if (last_dwell !== 19'(FAULT_DWELL)) begin fails++; $display("FAIL timing_last_dwell: got %0d expected %0d", last_dwell, FAULT_DWELL); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL timing_locked: got %0b expected 0", locked); end
        apply(4'b0001, 9);
        $display("test_timing_fault done");
    endtask

    task automatic test_seq_priority();
        lock_up(4'b0010);             // ends locked on 0010
        apply(4'b0100, 8);            // good step, but held only 8
        apply(4'b0001, 1);            // wrong step and short dwell
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL prio_err: got %0b expected 1", err); end
        checks++; if (err_code !== 2'd1) begin fails++; $display("FAIL prio_err_code: got %0d expected 1", err_code); end
        checks++; if (last_dwell !== 19'd8) begin fails++; $display("FAIL prio_last_dwell: got %0d expected 8", last_dwell); end
        apply(4'b0001, 9);
        $display("test_seq_priority done");
    endtask

    task automatic test_non_onehot();
        int base;
        base = err_pulses;
        apply(4'b0011, 10);           // SEARCH change, unchecked
        apply(4'b0110, 1);            // correct rotate of 0011, good dwell, not one-hot
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL onehot_err: got %0b expected 1", err); end
        checks++; if (err_code !== 2'd1) begin fails++; $display("FAIL onehot_err_code: got %0d expected 1", err_code); end
        apply(4'b0110, 9);
        checks++; if (err_pulses !== base + 1) begin fails++; $display("FAIL onehot_pulse_count: got %0d expected %0d", err_pulses, base + 1); end
        $display("test_non_onehot done");
    endtask

    task automatic test_boundaries();
        lock_up(4'b0001);             // ends locked on 0001
        apply(4'b0010, 9);
        apply(4'b0100, 1);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL bound9_err: got %0b expected 0", err); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL bound9_locked: got %0b expected 1", locked); end
        checks++; if (last_dwell !== 19'd9) begin fails++; $display("FAIL bound9_last_dwell: got %0d expected 9", last_dwell); end
        apply(4'b0100, 10);
        apply(4'b1000, 1);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL bound11_err: got %0b expected 0", err); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL bound11_locked: got %0b expected 1", locked); end
        checks++; if (last_dwell !== 19'd11) begin fails++; $display("FAIL bound11_last_dwell: got %0d expected 11", last_dwell); end
        apply(4'b1000, 7);
        apply(4'b0001, 1);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL bound8_err: got %0b expected 1", err); end
        checks++; if (err_code !== 2'd2) begin fails++; $display("FAIL bound8_err_code: got %0d expected 2", err_code); end
        checks++; if (last_dwell !== 19'd8) begin fails++; $display("FAIL bound8_last_dwell: got %0d expected 8", last_dwell); end
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL bound8_locked: got %0b expected 0", locked); end
        apply(4'b0001, 9);
        $display("test_boundaries done");
    endtask

    task automatic test_stall();
        int         base;
        logic       exp_err;
        logic [1:0] exp_code;
        logic       exp_locked;
        exp_err    = STALL;
        exp_code   = STALL ? 2'd3 : 2'd2;
        exp_locked = !STALL;
        lock_up(4'b0010);             // ends locked on 0010
        base = err_pulses;
        apply(4'b0100, 12);           // counter now reads 12
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL stall_err_early: got %0b expected 0", err); end
        apply(4'b0100, 1);
        checks++; if (err !== exp_err) begin fails++; $display("FAIL stall_err: got %0b expected %0b", err, exp_err); end
        checks++; if (err_code !== exp_code) begin fails++; $display("FAIL stall_err_code: got %0d expected %0d", err_code, exp_code); end
        checks++; if (locked !== exp_locked) begin fails++; $display("FAIL stall_locked: got %0b expected %0b", locked, exp_locked); end
        apply(4'b0100, 20);
        checks++; if (err_pulses !== base + int'(exp_err)) begin fails++; $display("FAIL stall_pulse_count: got %0d expected %0d", err_pulses, base + int'(exp_err)); end
        $display("test_stall done");
    endtask

    task automatic test_reset_mid_locked();
        int base;
        pattern = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lock_up(4'b0001);             // ends locked on 0001
        apply(4'b0010, 5);            // mid-dwell
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL rstmid_locked: got %0b expected 0", locked); end
        checks++; if (err_code !== 2'd0) begin fails++; $display("FAIL rstmid_err_code: got %0d expected 0", err_code); end
        checks++; if (last_dwell !== 19'd0) begin fails++; $display("FAIL rstmid_last_dwell: got %0d expected 0", last_dwell); end
        checks++; if (change_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_change_cnt: got %0d expected 0", change_cnt); end
        rst_n = 1'b1;
        base = err_pulses;
        apply(4'b0010, 10);           // 0000 -> 0010: SEARCH change
        apply(4'b0100, 10);
        apply(4'b1000, 10);
        apply(4'b0001, 10);
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL rstmid_relock_early: got %0b expected 0", locked); end
        apply(4'b0010, 10);
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL rstmid_relock: got %0b expected 1", locked); end
        checks++; if (change_cnt !== 16'd5) begin fails++; $display("FAIL rstmid_change_cnt_after: got %0d expected 5", change_cnt); end
        checks++; if (err_pulses !== base) begin fails++; $display("FAIL rstmid_no_err: got %0d expected %0d", err_pulses, base); end
        $display("test_reset_mid_locked done");
    endtask

    task automatic test_wrap();
        int base;
        pattern = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // 65530 one-cycle changes; pairs leave the FSM in SEARCH
        for (int i = 0; i < 65530; i++) begin
            pattern = i[0] ? 4'b0010 : 4'b0001;
            @(negedge clk);
        end
        apply(4'b0010, 5);
        base = err_pulses;
        apply(4'b0100, 10);
        apply(4'b1000, 10);
        apply(4'b0001, 10);
        apply(4'b0010, 10);
        apply(4'b0100, 10);
        checks++; if (change_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre: got %0d expected 65535", change_cnt); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_locked_pre: got %0b expected 1", locked); end
        apply(4'b1000, 10);
        checks++; if (change_cnt !== 16'd0) begin fails++; $display("FAIL wrap_post: got %0d expected 0", change_cnt); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_locked_post: got %0b expected 1", locked); end
        checks++; if (last_dwell !== 19'd10) begin fails++; $display("FAIL wrap_last_dwell: got %0d expected 10", last_dwell); end
        checks++; if (err_pulses !== base) begin fails++; $display("FAIL wrap_no_err: got %0d expected %0d", err_pulses, base); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_sequence_fault();
        test_timing_fault();
        test_seq_priority();
        test_non_onehot();
        test_boundaries();
        test_stall();
        test_reset_mid_locked();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
